// File: rtl/mii_net_crc32_stream_if.sv
// Byte-stream bundle for the inline CRC-32 engine: upstream beats in, registered beats out,
// plus the CRC status that rides alongside.
interface mii_net_crc32_stream_if #(
  parameter int DATA_BYTES = 1
);
  localparam int KEEP_W = $clog2(DATA_BYTES) + 1;

  logic                    i_mode;
  logic                    i_abort;
  logic [8*DATA_BYTES-1:0] i_data;
  logic                    i_valid;
  logic                    i_last;
  logic [KEEP_W-1:0]       i_keep;
  logic                    o_ready;
  logic [8*DATA_BYTES-1:0] o_data;
  logic                    o_valid;
  logic                    o_last;
  logic [KEEP_W-1:0]       o_keep;
  logic                    i_ready;
  logic [31:0]             o_crc_reg;
  logic                    o_fcs_done;
  logic                    o_fcs_ok;

  modport slave (
    input  i_mode, i_abort, i_data, i_valid, i_last, i_keep, i_ready,
    output o_ready, o_data, o_valid, o_last, o_keep, o_crc_reg, o_fcs_done, o_fcs_ok
  );

  modport master (
    output i_mode, i_abort, i_data, i_valid, i_last, i_keep, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_keep, o_crc_reg, o_fcs_done, o_fcs_ok
  );
endinterface

// File: rtl/mii_net_crc32_stream.sv
// Inline 802.3 CRC-32 on a DATA_BYTES-wide stream: appends the FCS as trailing beats in
// append mode, or checks the received FCS against the residue in check mode.
module mii_net_crc32_stream #(
  parameter int DATA_BYTES = 1
) (
  input logic                  i_clk,
  input logic                  i_reset,
  mii_net_crc32_stream_if.slave bus
);
  localparam int          KEEP_W      = $clog2(DATA_BYTES) + 1;
  localparam int          W           = 8 * DATA_BYTES;
  localparam int          NBEATS      = 4 / DATA_BYTES;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  // Bit-serial form of the reflected table step T[(crc ^ b) & 0xFF] ^ (crc >> 8).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  typedef enum logic [0:0] {S_DATA = 1'b0, S_FCS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              first_q, first_d;
  logic [31:0]       crc_q, crc_d;
  logic [31:0]       fcs_q, fcs_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [W-1:0]      data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;

  logic              slot_free_s;
  logic              ready_s;
  logic              in_xfer_s;
  logic              mode_s;
  logic [KEEP_W-1:0] nbytes_s;
  logic [31:0]       crc_next_s;
  logic [31:0]       fcs_sh_s;

  assign slot_free_s = ~valid_q | bus.i_ready;
  assign ready_s     = (state_q == S_DATA) & slot_free_s;
  assign in_xfer_s   = bus.i_valid & ready_s;
  assign mode_s      = first_q ? bus.i_mode : mode_q;
  assign fcs_sh_s    = fcs_q >> (int'(cnt_q) * W);

  // Byte count of the current beat and the CRC after folding those bytes in wire order.
  always_comb begin
    if (bus.i_last && (bus.i_keep != {KEEP_W{1'b0}})) begin
      nbytes_s = bus.i_keep;
    end else begin
      nbytes_s = KEEP_W'(DATA_BYTES);
    end
    crc_next_s = crc_q;
    for (int b = 0; b < DATA_BYTES; b++) begin
      crc_next_s = (b < int'(nbytes_s)) ? crc32_byte(crc_next_s, bus.i_data[8*b +: 8])
                                        : crc_next_s;
    end
  end

  // Next-state logic for the frame FSM and the output register stage.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    first_d = first_q;
    crc_d   = crc_q;
    fcs_d   = fcs_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    keep_d  = keep_q;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (bus.i_abort) begin
      valid_d = 1'b0;
      state_d = S_DATA;
      crc_d   = CRC_INIT;
      cnt_d   = 2'd0;
      first_d = 1'b1;
    end else begin
      case (state_q)
        S_DATA: begin
          if (in_xfer_s) begin
            data_d  = bus.i_data;
            valid_d = 1'b1;
            mode_d  = mode_s;
            first_d = bus.i_last;
            keep_d  = nbytes_s;
            if (!bus.i_last) begin
              last_d = 1'b0;
              crc_d  = crc_next_s;
            end else if (mode_s) begin
              last_d = 1'b1;
              done_d = 1'b1;
              ok_d   = (crc_next_s == CRC_RESIDUE);
              crc_d  = CRC_INIT;
            end else begin
              // The FCS beats carry o_last, so the final data beat does not.
              last_d  = 1'b0;
              crc_d   = crc_next_s;
              fcs_d   = ~crc_next_s;
              cnt_d   = 2'd0;
              state_d = S_FCS;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_FCS: begin
          if (slot_free_s) begin
            data_d  = fcs_sh_s[W-1:0];
            valid_d = 1'b1;
            keep_d  = KEEP_W'(DATA_BYTES);
            if (cnt_q == 2'(NBEATS - 1)) begin
              last_d  = 1'b1;
              cnt_d   = 2'd0;
              crc_d   = CRC_INIT;
              state_d = S_DATA;
            end else begin
              last_d = 1'b0;
              cnt_d  = cnt_q + 2'd1;
            end
          end else begin
            state_d = S_FCS;
          end
        end
        default: begin
          state_d = S_DATA;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_DATA;
      mode_q  <= 1'b0;
      first_q <= 1'b1;
      crc_q   <= CRC_INIT;
      fcs_q   <= 32'd0;
      cnt_q   <= 2'd0;
      data_q  <= {W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      keep_q  <= {KEEP_W{1'b0}};
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      crc_q   <= crc_d;
      fcs_q   <= fcs_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  assign bus.o_ready    = ready_s;
  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_last     = last_q;
  assign bus.o_keep     = keep_q;
  assign bus.o_crc_reg  = crc_q;
  assign bus.o_fcs_done = done_q;
  assign bus.o_fcs_ok   = ok_q;
endmodule

// File: tb/tb_mii_net_crc32_stream.sv
// Scoreboard bench for mii_net_crc32_stream at DATA_BYTES = 1, 2 and 4 using the
// "123456789" check string (CRC-32 0xCBF43926).
module tb_mii_net_crc32_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mii_net_crc32_stream_if #(.DATA_BYTES(1)) bus1();
  mii_net_crc32_stream_if #(.DATA_BYTES(2)) bus2();
  mii_net_crc32_stream_if #(.DATA_BYTES(4)) bus4();

  mii_net_crc32_stream #(.DATA_BYTES(1)) u1 (.i_clk(clk), .i_reset(rst), .bus(bus1));
  mii_net_crc32_stream #(.DATA_BYTES(2)) u2 (.i_clk(clk), .i_reset(rst), .bus(bus2));
  mii_net_crc32_stream #(.DATA_BYTES(4)) u4 (.i_clk(clk), .i_reset(rst), .bus(bus4));

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  keep;
  } beat_t;

  beat_t q1[$], q2[$], q4[$];
  bit    f1[$], f2[$], f4[$];
  beat_t e1, e2, e4;
  bit    ok1, ok2, ok4;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic stray(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected output %h with nothing expected", name, act);
  endtask

  // Monitors: pop and compare on every output transfer and every fcs_done pulse.
  always @(negedge clk) begin
    if (!rst && bus1.o_valid && bus1.i_ready) begin
      if (q1.size() == 0) stray("u1 beat", 32'(bus1.o_data));
      else begin
        e1 = q1.pop_front();
        check("u1 data", 32'(bus1.o_data), e1.data);
        check("u1 last", 32'(bus1.o_last), 32'(e1.last));
        check("u1 keep", 32'(bus1.o_keep), 32'(e1.keep));
      end
    end
    if (!rst && bus1.o_fcs_done) begin
      if (f1.size() == 0) stray("u1 fcs_done", 32'(bus1.o_fcs_ok));
      else begin ok1 = f1.pop_front(); check("u1 fcs_ok", 32'(bus1.o_fcs_ok), 32'(ok1)); end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus2.o_valid && bus2.i_ready) begin
      if (q2.size() == 0) stray("u2 beat", 32'(bus2.o_data));
      else begin
        e2 = q2.pop_front();
        check("u2 data", 32'(bus2.o_data), e2.data);
        check("u2 last", 32'(bus2.o_last), 32'(e2.last));
        check("u2 keep", 32'(bus2.o_keep), 32'(e2.keep));
      end
    end
    if (!rst && bus2.o_fcs_done) begin
      if (f2.size() == 0) stray("u2 fcs_done", 32'(bus2.o_fcs_ok));
      else begin ok2 = f2.pop_front(); check("u2 fcs_ok", 32'(bus2.o_fcs_ok), 32'(ok2)); end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.o_valid && bus4.i_ready) begin
      if (q4.size() == 0) stray("u4 beat", 32'(bus4.o_data));
      else begin
        e4 = q4.pop_front();
        check("u4 data", 32'(bus4.o_data), e4.data);
        check("u4 last", 32'(bus4.o_last), 32'(e4.last));
        check("u4 keep", 32'(bus4.o_keep), 32'(e4.keep));
      end
    end
    if (!rst && bus4.o_fcs_done) begin
      if (f4.size() == 0) stray("u4 fcs_done", 32'(bus4.o_fcs_ok));
      else begin ok4 = f4.pop_front(); check("u4 fcs_ok", 32'(bus4.o_fcs_ok), 32'(ok4)); end
    end
  end

  task automatic drive(input int sel, input logic [31:0] d, input logic v, input logic last,
                       input logic [2:0] keep);
    case (sel)
      1: begin bus1.i_data = d[7:0];  bus1.i_valid = v; bus1.i_last = last; bus1.i_keep = keep[0:0]; end
      2: begin bus2.i_data = d[15:0]; bus2.i_valid = v; bus2.i_last = last; bus2.i_keep = keep[1:0]; end
      4: begin bus4.i_data = d;       bus4.i_valid = v; bus4.i_last = last; bus4.i_keep = keep; end
      default: ;
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      1: return bus1.o_ready;
      2: return bus2.o_ready;
      4: return bus4.o_ready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic expect_beat(input int sel, input logic [31:0] d, input logic last,
                             input logic [2:0] keep);
    beat_t e;
    e.data = d;
    e.last = last;
    e.keep = keep;
    case (sel)
      1: q1.push_back(e);
      2: q2.push_back(e);
      4: q4.push_back(e);
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic send(input int sel, input logic [31:0] d, input logic last, input logic [2:0] keep);
    logic r;
    int   n;
    n = 0;
    drive(sel, d, 1'b1, last, keep);
    forever begin
      @(negedge clk);
      r = rdy(sel);
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 100) begin
        stray("send timeout", d);
        break;
      end
    end
    #1;
    drive(sel, 32'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // "123456789" on the 1-byte instance; how: 0 plain, 1 FCS backpressure, 2 reset mid-FCS.
  task automatic frame123(input int how);
    logic [7:0] fcs_b[4];
    fcs_b[0] = 8'h26; fcs_b[1] = 8'h39; fcs_b[2] = 8'hF4; fcs_b[3] = 8'hCB;
    for (int i = 0; i < 9; i++) expect_beat(1, 32'h31 + 32'(i), 1'b0, 3'd1);
    for (int i = 0; i < 4; i++) begin
      if (how != 2 || i == 0) expect_beat(1, {24'd0, fcs_b[i]}, (i == 3), 3'd1);
    end
    for (int i = 0; i < 9; i++) send(1, 32'h31 + 32'(i), (i == 8), 3'd1);
    idle(2);
    if (how == 1) begin
      bus1.i_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        check("bp o_data held", 32'(bus1.o_data), 32'h39);
        check("bp o_valid held", 32'(bus1.o_valid), 32'd1);
        check("bp o_ready low", 32'(bus1.o_ready), 32'd0);
        @(posedge clk);
        #1;
      end
      bus1.i_ready = 1'b1;
    end else if (how == 2) begin
      rst = 1'b1;
      #1;
      check("rst o_valid", 32'(bus1.o_valid), 32'd0);
      check("rst o_data", 32'(bus1.o_data), 32'd0);
      check("rst o_last", 32'(bus1.o_last), 32'd0);
      check("rst o_keep", 32'(bus1.o_keep), 32'd0);
      check("rst o_crc_reg", bus1.o_crc_reg, 32'hFFFF_FFFF);
      check("rst o_ready", 32'(bus1.o_ready), 32'd1);
      check("rst beats drained", 32'(q1.size()), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    idle(8);
  endtask

  task automatic check_frame2(input logic [7:0] fcs_last, input bit ok);
    logic [15:0] b[7];
    b[0] = 16'h3231; b[1] = 16'h3433; b[2] = 16'h3635; b[3] = 16'h3837;
    b[4] = 16'h2639; b[5] = 16'hF439; b[6] = {8'h00, fcs_last};
    for (int i = 0; i < 7; i++) expect_beat(2, {16'd0, b[i]}, (i == 6), (i == 6) ? 3'd1 : 3'd2);
    f2.push_back(ok);
    for (int i = 0; i < 7; i++) send(2, {16'd0, b[i]}, (i == 6), (i == 6) ? 3'd1 : 3'd2);
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit %0t reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus1.i_mode = 1'b0; bus1.i_abort = 1'b0; bus1.i_ready = 1'b1;
    bus2.i_mode = 1'b1; bus2.i_abort = 1'b0; bus2.i_ready = 1'b1;
    bus4.i_mode = 1'b0; bus4.i_abort = 1'b0; bus4.i_ready = 1'b1;
    for (int s = 1; s <= 4; s *= 2) drive(s, 32'd0, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset o_valid", 32'(bus1.o_valid), 32'd0);
    check("reset o_data", 32'(bus1.o_data), 32'd0);
    check("reset o_keep", 32'(bus1.o_keep), 32'd0);
    check("reset o_fcs_done", 32'(bus1.o_fcs_done), 32'd0);
    check("reset o_crc_reg", bus1.o_crc_reg, 32'hFFFF_FFFF);
    check("reset u4 o_crc_reg", bus4.o_crc_reg, 32'hFFFF_FFFF);
    rst = 1'b0;
    idle(1);

    // Append, 1 byte/beat.
    frame123(0);
    check("u1 crc reinit", bus1.o_crc_reg, 32'hFFFF_FFFF);

    // Append, 4 bytes/beat with a partial last beat.
    expect_beat(4, 32'h3433_3231, 1'b0, 3'd4);
    expect_beat(4, 32'h3837_3635, 1'b0, 3'd4);
    expect_beat(4, 32'h0000_0039, 1'b0, 3'd1);
    expect_beat(4, 32'hCBF4_3926, 1'b1, 3'd4);
    send(4, 32'h3433_3231, 1'b0, 3'd4);
    send(4, 32'h3837_3635, 1'b0, 3'd4);
    send(4, 32'h0000_0039, 1'b1, 3'd1);
    idle(6);
    check("u4 crc reinit", bus4.o_crc_reg, 32'hFFFF_FFFF);

    // Check mode, 2 bytes/beat: good FCS then corrupted FCS.
    check_frame2(8'hCB, 1'b1);
    check_frame2(8'hCA, 1'b0);
    check("u2 crc reinit", bus2.o_crc_reg, 32'hFFFF_FFFF);

    // Backpressure during the FCS beats.
    frame123(1);

    // Abort after three bytes; the beat presented with the abort must be dropped.
    for (int i = 0; i < 3; i++) expect_beat(1, 32'h41 + 32'(i), 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) send(1, 32'h41 + 32'(i), 1'b0, 3'd1);
    bus1.i_abort = 1'b1;
    drive(1, 32'h44, 1'b1, 1'b0, 3'd1);
    @(posedge clk);
    #1;
    bus1.i_abort = 1'b0;
    drive(1, 32'd0, 1'b0, 1'b0, 3'd0);
    check("abort o_valid", 32'(bus1.o_valid), 32'd0);
    check("abort o_crc_reg", bus1.o_crc_reg, 32'hFFFF_FFFF);
    idle(2);
    frame123(0);

    // Reset between FCS bytes, then a clean frame.
    frame123(2);
    frame123(0);

    idle(4);
    check("q1 empty", 32'(q1.size()), 32'd0);
    check("q2 empty", 32'(q2.size()), 32'd0);
    check("q4 empty", 32'(q4.size()), 32'd0);
    check("f1 empty", 32'(f1.size()), 32'd0);
    check("f2 empty", 32'(f2.size()), 32'd0);
    check("f4 empty", 32'(f4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
